// File: rtl/vc_valrdy_rr_merge.sv
// Round-robin merge of p_num_reqs val/rdy producers into one registered val/rdy output.
// Optional build macro VC_VALRDY_RR_MERGE_TAG_EN prepends the winning requester index to out_msg.
module vc_valrdy_rr_merge #(
   parameter int p_num_reqs  = 4,
   parameter int p_msg_nbits = 8
)(
   input  logic                                clk,
   input  logic                                reset,
   input  logic [p_num_reqs-1:0]               in_val,
   output logic [p_num_reqs-1:0]               in_rdy,
   input  logic [p_num_reqs*p_msg_nbits-1:0]   in_msg,
   output logic                                out_val,
   input  logic                                out_rdy,
`ifdef VC_VALRDY_RR_MERGE_TAG_EN
   output logic [p_msg_nbits+$clog2(p_num_reqs)-1:0] out_msg
`else
   output logic [p_msg_nbits-1:0]              out_msg
`endif
);

   localparam int                     c_idx_nbits = $clog2(p_num_reqs);
   localparam logic [c_idx_nbits-1:0] c_last_idx  = c_idx_nbits'(p_num_reqs - 1);
   localparam logic [c_idx_nbits-1:0] c_one       = c_idx_nbits'(1);

   logic                   full_r;
   logic [p_msg_nbits-1:0] data_r;
   logic [c_idx_nbits-1:0] ptr_r;

   logic                   grant_val_s;
   logic [c_idx_nbits-1:0] winner_s;
   logic [c_idx_nbits-1:0] ptr_next_s;
   logic [p_msg_nbits-1:0] sel_msg_s;
   logic                   space_s;
   logic                   xfer_s;

   // Scan requesters starting at ptr_r, wrapping modulo p_num_reqs, and pick the first valid one.
   always_comb begin
      grant_val_s = 1'b0;
      winner_s    = '0;
      for (int k = 0; k < p_num_reqs; k++) begin
         int idx;
         idx = int'(ptr_r) + k;
         if (idx >= p_num_reqs) begin
            idx = idx - p_num_reqs;
         end else begin
            idx = idx;
         end
         if (!grant_val_s && in_val[idx]) begin
            grant_val_s = 1'b1;
            winner_s    = idx[c_idx_nbits-1:0];
         end else begin
            grant_val_s = grant_val_s;
         end
      end
   end

   assign space_s   = !full_r || out_rdy;
   assign xfer_s    = !reset && grant_val_s && space_s;
   assign sel_msg_s = in_msg[int'(winner_s)*p_msg_nbits +: p_msg_nbits];

   // One-hot ready to the winner only when the output register can accept; zero during reset.
   always_comb begin
      in_rdy = '0;
      if (xfer_s) begin
         in_rdy[winner_s] = 1'b1;
      end else begin
         in_rdy = '0;
      end
   end

   // Next priority pointer is the requester after the winner, wrapping at the last index.
   always_comb begin
      ptr_next_s = '0;
      if (winner_s == c_last_idx) begin
         ptr_next_s = '0;
      end else begin
         ptr_next_s = winner_s + c_one;
      end
   end

   // Occupancy and priority pointer; a refill while draining keeps full_r set.
   always_ff @(posedge clk) begin
      if (reset) begin
         full_r <= 1'b0;
         ptr_r  <= '0;
      end else if (xfer_s) begin
         full_r <= 1'b1;
         ptr_r  <= ptr_next_s;
      end else if (out_rdy) begin
         full_r <= 1'b0;
      end else begin
         full_r <= full_r;
      end
   end

   // Payload register, loaded only on an input transfer so it holds steady while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_r <= '0;
      end else if (xfer_s) begin
         data_r <= sel_msg_s;
      end else begin
         data_r <= data_r;
      end
   end

   assign out_val = full_r;

`ifdef VC_VALRDY_RR_MERGE_TAG_EN
   logic [c_idx_nbits-1:0] tag_r;

   // Requester index captured alongside the payload.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_r <= '0;
      end else if (xfer_s) begin
         tag_r <= winner_s;
      end else begin
         tag_r <= tag_r;
      end
   end

   assign out_msg = {tag_r, data_r};
`else
   assign out_msg = data_r;
`endif

endmodule

// File: doc/vc_valrdy_rr_merge.md
# vc_valrdy_rr_merge

Round-robin merge unit that shares one val/rdy consumer between `p_num_reqs` val/rdy producers. It sits between several `vc_TestSource` instances, or producer datapaths, and a single `vc_TestSink` or shared downstream unit. It arbitrates fairly per message and holds the winning message in a one-entry output register, sustaining one message per cycle.

## Interface
- `p_num_reqs`, 4: number of requester streams; 2..16.
- `p_msg_nbits`, 8: payload width per message.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_val`  in  `p_num_reqs`  per-requester valid; bit i is requester i.
- `in_rdy`  out  `p_num_reqs`  per-requester ready; at most one bit high (one-hot or zero).
- `in_msg`  in  `p_num_reqs*p_msg_nbits`  flattened payloads; requester i occupies `[i*p_msg_nbits +: p_msg_nbits]`.
- `out_val`  out  1  output register holds a valid message.
- `out_rdy`  in  1  consumer ready.
- `out_msg`  out  `p_msg_nbits` (+ tag, see Configuration)  output payload.

## Operation
- State:
  - Output register `{full, data}`.
  - Priority pointer `ptr`, `clog2(p_num_reqs)` bits; requester `ptr` has highest priority.
- Arbitration (combinational):
  - Winner = first i with `in_val[i]` high, scanning `ptr, ptr+1, …, p_num_reqs-1, 0, …, ptr-1`.
  - No winner if `in_val` is all zero.
- `space = !full || out_rdy`. The register is free or drains this cycle.
- `in_rdy[winner] = space`; all other `in_rdy` bits are 0.
  - `in_rdy` depends combinationally on `in_val` and `out_rdy`.
  - Producers must not drive `in_val` from `in_rdy`.
- Input transfer: `in_val[i] && in_rdy[i]`.
  - On the next edge, `data <= msg[i]`, `full <= 1`, `ptr <= (i+1) mod p_num_reqs`.
- Output transfer: `out_val && out_rdy`.
  - With no input transfer in the same cycle: `full <= 0`.
  - With an input transfer in the same cycle: the register is overwritten with the new message (bypass-free refill).
- `ptr` is unchanged in any cycle without an input transfer. Stalled requesters keep priority order; a requester denied this cycle is not skipped.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N-1,0…. Each requester waits at most N-1 input transfers.
- `out_val = full`; `out_msg = data`.
- Stall: `full && !out_rdy` → all `in_rdy` are 0 and `data` is held stable. Producers keep `in_val` and `in_msg` stable until accepted (val/rdy protocol).
- Pointer wrap: `ptr` = N-1 plus a grant to N-1 → `ptr` = 0. Arithmetic is mod `p_num_reqs`, including non-power-of-2 N.

## Timing
- Latency: an input accepted in cycle t appears as `out_val` = 1 from cycle t+1.
- Throughput: 1 message/cycle when `out_rdy` is held high.
- Reset (while `reset` = 1 at the edge): `full` = 0, `ptr` = 0, `out_val` = 0.
  - `in_rdy` is forced to all zeros while `reset` is high, regardless of `in_val` and `out_rdy`.
  - `data` is don't-care; `out_msg` is undefined until the first transfer.
- Reset mid-operation: any message held in the register is dropped, with no output transfer. Arbitration restarts at requester 0 in the first cycle after `reset` falls.
- Simultaneous drain and fill on a full register: both occur; `full` stays 1 and throughput is not lost.

## Configuration
- Macro: `VC_VALRDY_RR_MERGE_TAG_EN`.
- Defined:
  - `out_msg` widens to `p_msg_nbits + clog2(p_num_reqs)` bits.
  - The upper `clog2(p_num_reqs)` bits hold the winning requester index, registered with `data`.
  - The lower bits hold the payload.
- Undefined: `out_msg` is exactly `p_msg_nbits` bits with no tag logic; behaviour is otherwise identical.

## Test plan
- **Reset.** Hold `reset` for 2 cycles with `in_val`=4'b1111 and `out_rdy`=1 → `out_val`=0 and `in_rdy`=0 throughout. After release, the first grant goes to requester 0: `in_rdy`=4'b0001.
- **Round-robin rotation.** N=4, all sources always valid with msgs 0xA0+i, `out_rdy`=1 → `out_msg` sequence A0,A1,A2,A3,A0…, one per cycle starting 1 cycle after the first grant.
- **Sparse requests.** Only requesters 1 and 3 valid, `ptr`=0 → grants 1,3,1,3. Requester 2 becoming valid after a grant to 1 is served before 3.
- **Backpressure.**
  - `out_rdy`=0 for 5 cycles while full → `in_rdy`=0, `out_msg` stable, `ptr` unchanged.
  - On `out_rdy`=1, drain and refill occur in the same cycle.
- **Source/sink harness.** Four `vc_TestSource` instances, each with 6 distinct 8-bit messages, merge into one `vc_TestSink`; the sink expects the round-robin interleaving. With random sink delays, `done` asserts within 5000 cycles, and all 24 messages arrive in the expected order.
- **Tag build with `VC_VALRDY_RR_MERGE_TAG_EN`.** N=4: a message 0x5C from requester 2 gives `out_msg`=10'b10_0101_1100.
